// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver feeding a first-word-fall-through
// receive FIFO with per-entry frame/parity/break status and sticky overflow.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | line idle, waiting for a falling edge while rx_en is high
// S_START  | confirming the start bit at its midpoint (glitch filter)
// S_DATA   | sampling PAYLOAD_BITS data bits mid-bit, LSB first
// S_PARITY | sampling the parity bit (UART_RX_PARITY_EN builds only)
// S_STOP   | sampling STOP_BITS stop bits, then pushing the entry
module uart_rx_fifo #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            uart_rxd,
  input  logic                            rx_en,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [PAYLOAD_BITS-1:0]         m_data,
  output logic                            m_frame_err,
  output logic                            m_parity_err,
  output logic                            m_break,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  input  logic                            ovf_clr,
  output logic                            rx_busy
);

  localparam int CPB     = CLK_HZ / BIT_RATE;
  localparam int CNT_W   = $clog2(CPB);
  localparam int ENTRY_W = PAYLOAD_BITS + 3;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int FCNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CPB - 1);
  localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic             PAR_SENSE = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                    rxd_meta_q, rxd_s_q;
  logic [2:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [3:0]              bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    ferr_q, ferr_d;
  logic                    push;
  logic                    push_ferr, push_perr, push_brk;
  logic                    tick;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  assign tick = (cnt_q == BIT_TC);

  // Receive FSM next-state; the bit counter restarts on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d  = 1'b0;
        perr_d = 1'b0;
`endif
        if (rx_en && !rxd_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[PAYLOAD_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          par_d   = rxd_s_q;
          perr_d  = ((^shift_q) ^ rxd_s_q) != PAR_SENSE;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (!rxd_s_q) ferr_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receive FSM registers; reset drops any partial frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // The last stop sample is folded in directly since it lands on the push cycle
  assign push_ferr = ferr_q | ~rxd_s_q;
`ifdef UART_RX_PARITY_EN
  assign push_perr = perr_q;
  assign push_brk  = push_ferr & (shift_q == '0) & ~par_q;
`else
  // Parity sense has no effect when no parity bit is on the wire
  assign push_perr = PAR_SENSE & 1'b0;
  assign push_brk  = push_ferr & (shift_q == '0);
`endif

  assign rx_busy = (state_q != S_IDLE);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [FCNT_W-1:0]  count_q;
  logic               overflow_q;
  logic               full, empty, pop, wr_en, drop;

  assign full  = (count_q == FCNT_W'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = m_ready & ~empty;
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // Storage array needs no reset; outputs are gated while empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= {push_brk, push_perr, push_ferr, shift_q};
  end

  // FIFO pointers, occupancy and sticky overflow (a new drop beats ovf_clr)
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (wr_en && !pop)      count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
      if (drop)         overflow_q <= 1'b1;
      else if (ovf_clr) overflow_q <= 1'b0;
    end
  end

  assign m_valid    = ~empty;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign {m_break, m_parity_err, m_frame_err, m_data} =
      empty ? '0 : mem_q[rd_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized bench for uart_rx_fifo at 10 clocks/bit, 8 data bits, 1 stop
// bit, 4-entry FIFO. Build with UART_RX_PARITY_EN to exercise parity.
module tb_uart_rx_fifo;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam bit PODD  = 1'b1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_en = 1'b1;
  logic       m_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       m_valid, m_frame_err, m_parity_err, m_break, overflow, rx_busy;
  logic [7:0] m_data;
  logic [2:0] fifo_count;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: queue of expected {break, parity_err, frame_err, data} words
  logic [10:0] exp_q[$];
  bit          ovf_exp = 1'b0;

  uart_rx_fifo #(
    .CLK_HZ(50_000_000), .BIT_RATE(5_000_000), .PAYLOAD_BITS(8),
    .STOP_BITS(1), .PARITY_ODD(int'(PODD)), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .rx_en(rx_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_frame_err(m_frame_err), .m_parity_err(m_parity_err), .m_break(m_break),
    .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr),
    .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] expect_word(input logic [7:0] d, input bit pbit, input bit ferr);
    int  ones;
    bit  perr, brk;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
`ifdef UART_RX_PARITY_EN
    perr = (((ones + int'(pbit)) % 2) == 1) != PODD;
    brk  = ferr && (d == 8'h00) && !pbit;
`else
    perr = 1'b0;
    brk  = ferr && (d == 8'h00);
    if (pbit) perr = 1'b0;
`endif
    return {brk, perr, ferr, d};
  endfunction

  task automatic model_frame(input logic [7:0] d, input bit pbit, input bit stop_ok);
    if (exp_q.size() == DEPTH) ovf_exp = 1'b1;
    else exp_q.push_back(expect_word(d, pbit, !stop_ok));
  endtask

  task automatic send_bit(input logic b);
    uart_rxd = b;
    cyc(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop_ok, input bit drop_en);
    send_bit(1'b0);
    if (drop_en) rx_en = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop_ok);
    rx_en = 1'b1;
    uart_rxd = 1'b1;
    cyc(2 * CPB);
    model_frame(d, pbit, stop_ok);
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      check({tag, "_valid"}, 32'(m_valid), 32'd1);
      check({tag, "_entry"}, {m_break, m_parity_err, m_frame_err, m_data}, 32'(exp_q[0]));
      cyc(2);
      check({tag, "_hold"}, {m_break, m_parity_err, m_frame_err, m_data}, 32'(exp_q[0]));
      m_ready = 1'b1;
      cyc(1);
      m_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    check({tag, "_empty"}, {m_valid, m_data}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"},
          {m_valid, m_data, m_frame_err, m_parity_err, m_break, fifo_count, overflow, rx_busy},
          32'd0);
  endtask

  initial begin
    cyc(3);
    check_reset_state("reset");
    reset = 1'b0;
    cyc(5);

    // Single clean frame stays at the head while m_ready is low
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("a5_valid", 32'(m_valid), 32'd1);
    check("a5_data", 32'(m_data), 32'hA5);
    check("a5_flags", {m_frame_err, m_parity_err, m_break}, 32'd0);
    check("a5_count", 32'(fifo_count), 32'd1);
    drain("a5");

    // Short low pulse is rejected by the start-bit midpoint check
    uart_rxd = 1'b0;
    cyc(3);
    uart_rxd = 1'b1;
    cyc(2);
    check("glitch_busy", 32'(rx_busy), 32'd1);
    cyc(5);
    check("glitch_idle", 32'(rx_busy), 32'd0);
    cyc(10);
    check("glitch_count", 32'(fifo_count), 32'd0);

    // Framing error and break
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("ferr_flags", {m_frame_err, m_break}, 32'b10);
    drain("ferr");
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    check("brk_flags", {m_frame_err, m_break}, 32'b11);
    drain("brk");

    // Five frames into four entries: last one dropped, overflow sticky
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'(ovf_exp));
    drain("ovf");
    check("ovf_kept", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 32'd0);
    ovf_exp = 1'b0;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    check("par_err1", 32'(m_parity_err), 32'd1);
    drain("par1");
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    check("par_err0", 32'(m_parity_err), 32'd0);
    drain("par0");
`endif

    // Reset during data bit 4 discards both the FIFO and the partial frame
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'hC3 >> i));
    uart_rxd = 1'b1;
    cyc(5);
    reset = 1'b1;
    cyc(1);
    check_reset_state("midrst");
    reset = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
    cyc(3 * CPB);
    check("midrst_count", 32'(fifo_count), 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    check("after_rst_data", 32'(m_data), 32'h5A);
    drain("after_rst");

    // Randomized rounds: bursts with m_ready low, occasional bad stop,
    // zero data, and rx_en dropped mid-frame
    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(1, 5));
      for (int k = 0; k < n; k++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        send_frame(d, 1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom));
      end
      check("rnd_ovf", 32'(overflow), 32'(ovf_exp));
      ovf_clr = 1'b1;
      cyc(1);
      ovf_clr = 1'b0;
      ovf_exp = 1'b0;
      drain("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BIT_RATE, default 9600, line rate in bits/s; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division), SHALL be >= 4.
REQ-003 Parameter PAYLOAD_BITS, default 8, data bits per frame, legal 5..9.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame, legal 1..2.
REQ-005 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined.
REQ-006 Parameter FIFO_DEPTH, default 8, receive FIFO entries, power of two, >= 2.
REQ-007 One clock; reset is synchronous and active-high.
REQ-008 clk  in  1  system clock, all logic on rising edge.
REQ-009 reset  in  1  synchronous active-high reset.
REQ-010 uart_rxd  in  1  asynchronous serial receive pin, idle high.
REQ-011 rx_en  in  1  receive enable, sampled only in IDLE.
REQ-012 m_valid  out  1  FIFO head entry valid.
REQ-013 m_ready  in  1  consumer accepts head entry when m_valid & m_ready.
REQ-014 m_data  out  PAYLOAD_BITS  head entry data, LSB = first received bit.
REQ-015 m_frame_err / m_parity_err / m_break  out  1 each  head entry status flags.
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied entries.
REQ-017 overflow  out  1  sticky, frame dropped because FIFO full.
REQ-018 ovf_clr  in  1  clears overflow; set wins if coincident with a new drop.
REQ-019 rx_busy  out  1  high whenever FSM is not IDLE.

Function
REQ-020 uart_rxd SHALL pass through a two-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rxd_s.
REQ-021 FSM states IDLE, START, DATA, PARITY, STOP; cycle counter cleared on every state entry.
REQ-022 IDLE -> START when rx_en = 1 and rxd_s = 0; otherwise remain.
REQ-023 START: at count CYCLES_PER_BIT/2 - 1 sample rxd_s; 1 -> IDLE (glitch, nothing pushed); 0 -> DATA.
REQ-024 DATA: sample at every CYCLES_PER_BIT-th cycle (mid-bit), shift in LSB first; after PAYLOAD_BITS samples -> PARITY if UART_RX_PARITY_EN, else STOP.
REQ-025 PARITY: one sample after CYCLES_PER_BIT; parity_err = (XOR of data and parity bit) != PARITY_ODD; -> STOP.
REQ-026 STOP: sample STOP_BITS bits at CYCLES_PER_BIT spacing; any sample 0 sets frame_err; after the last stop sample push one entry and return to IDLE the next cycle (mid-stop-bit resync).
REQ-027 break = frame_err & data all zero & (parity bit zero when parity enabled).
REQ-028 rx_en deassertion mid-frame SHALL NOT abort the frame.
REQ-029 FIFO is first-word-fall-through; a pushed entry appears on m_* exactly one cycle after the push cycle when the FIFO was empty.
REQ-030 m_data and flags SHALL be stable while m_valid & !m_ready.
REQ-031 Push while full and no pop: entry dropped, overflow set, FIFO contents unchanged.
REQ-032 Push and pop same cycle while full: both accepted, no overflow, fifo_count unchanged.
REQ-033 Pop while empty is ignored; read/write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 Reset SHALL force IDLE, empty FIFO, m_valid 0, m_data 0, all flags 0, fifo_count 0, overflow 0, rx_busy 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; no push occurs.

Configuration
REQ-036 Macro UART_RX_PARITY_EN defined: PARITY state present, parity bit expected after data, m_parity_err reflects REQ-025.
REQ-037 UART_RX_PARITY_EN undefined: no PARITY state, no parity bit expected, m_parity_err tied 0, PARITY_ODD ignored.

Verification (CLK_HZ=50_000_000, BIT_RATE=5_000_000 -> 10 cycles/bit, 8 data, 1 stop, FIFO_DEPTH=4)
REQ-038 Send 0xA5 8N1, m_ready=0 -> m_valid=1, m_data=0xA5, all flags 0, fifo_count=1.
REQ-039 Drive uart_rxd low 3 cycles then high -> no push, rx_busy returns 0 by cycle 8, fifo_count=0.
REQ-040 Send 0x3C with stop bit 0 -> m_frame_err=1, m_break=0; send 0x00 with stop bit 0 -> m_break=1, m_frame_err=1.
REQ-041 Send 5 frames 0x01..0x05, m_ready=0 -> fifo_count=4, overflow=1, pops return 0x01..0x04; pulse ovf_clr -> overflow=0.
REQ-042 Macro defined, PARITY_ODD=1, send 0x07 with parity bit 1 -> m_parity_err=1; parity bit 0 -> m_parity_err=0.
REQ-043 Assert reset at data bit 4 of a frame -> all outputs at REQ-034 values next cycle, following clean frame 0x5A received correctly.
